// File: rtl/wb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module : wb_pwm_bank
// Wishbone-slave PWM bank: shared prescaler and period counter, double-buffered duties.
// Rev    : 1.0
// ============================================================================
module wb_pwm_bank #(
    parameter int CHANNELS       = 3,
    parameter int WIDTH          = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int PRESCALE_RESET = 1881
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [31:0]           dat_i,
    output logic [31:0]           dat_o,
    input  logic                  we_i,
    input  logic [3:0]            sel_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_tick
);

    localparam int                WORD_W        = ADDR_WIDTH - 2;
    localparam logic [WIDTH-1:0]  C_CNT_LAST    = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WORD_W-1:0] C_WORD_CTRL   = WORD_W'(0);
    localparam logic [WORD_W-1:0] C_WORD_PRE    = WORD_W'(1);
    localparam logic [WORD_W-1:0] C_WORD_STAT   = WORD_W'(2);
    localparam logic [WORD_W-1:0] C_WORD_DUTY0  = WORD_W'(4);
    localparam logic [WORD_W-1:0] C_NUM_CH      = WORD_W'(CHANNELS);

    logic                en_q, en_d;
    logic                inv_q, inv_d;
    logic [15:0]         prescale_q, prescale_d;
    logic [15:0]         pscnt_q, pscnt_d;
    logic [15:0]         pcount_q, pcount_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [31:0]         dat_q, dat_d;

    logic                w_req;
    logic                w_wr;
    logic                w_sel_ctrl;
    logic                w_sel_pre;
    logic                w_sel_stat;
    logic                w_sel_duty;
    logic                w_mapped;
    logic                w_tick;
    logic                w_wrap;
    logic [WORD_W-1:0]   w_word;
    logic [WORD_W-1:0]   w_duty_idx;
    logic [31:0]         w_mask;
    logic [31:0]         w_rdata;
    logic                w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign w_unused   = ^adr_i[1:0];
    assign w_req      = cyc_i & stb_i & ~ack_q & ~err_q;
    assign w_wr       = w_req & we_i;
    assign w_word     = adr_i[ADDR_WIDTH-1:2];
    assign w_duty_idx = w_word - C_WORD_DUTY0;
    assign w_sel_ctrl = (w_word == C_WORD_CTRL);
    assign w_sel_pre  = (w_word == C_WORD_PRE);
    assign w_sel_stat = (w_word == C_WORD_STAT);
    assign w_sel_duty = (w_word >= C_WORD_DUTY0) && (w_duty_idx < C_NUM_CH);
    assign w_mapped   = w_sel_ctrl | w_sel_pre | w_sel_stat | w_sel_duty;
    assign w_mask     = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

    // A count above PRESCALE (after a lowering write) wraps instead of overrunning.
    assign w_tick     = en_q && (pscnt_q >= prescale_q);
    assign w_wrap     = w_tick && (cnt_q == C_CNT_LAST);

    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl) begin
            w_rdata[1:0] = {inv_q, en_q};
        end else if (w_sel_pre) begin
            w_rdata[15:0] = prescale_q;
        end else if (w_sel_stat) begin
            w_rdata[WIDTH-1:0] = cnt_q;
            w_rdata[31:16]     = pcount_q;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_sel_duty && (w_duty_idx == WORD_W'(i)))
                    w_rdata[WIDTH-1:0] = shadow_q[i];
            end
        end
    end

    always_comb begin
        en_d       = en_q;
        inv_d      = inv_q;
        prescale_d = prescale_q;
        if (w_wr && w_sel_ctrl && sel_i[0]) begin
            en_d  = dat_i[0];
            inv_d = dat_i[1];
        end
        if (w_wr && w_sel_pre)
            prescale_d = 16'(f_merge({16'h0, prescale_q}, dat_i, w_mask));

        ack_d = w_req & w_mapped;
        err_d = w_req & ~w_mapped;
        dat_d = (w_req && w_mapped) ? w_rdata : 32'h0;

        pscnt_d  = (!en_q || w_tick) ? 16'h0 : pscnt_q + 16'd1;
        cnt_d    = cnt_q;
        if (!en_q || w_wrap)
            cnt_d = '0;
        else if (w_tick)
            cnt_d = cnt_q + WIDTH'(1);
        pcount_d = w_wrap ? pcount_q + 16'd1 : pcount_q;
        tick_d   = w_wrap;

        // Active duties sample the shadow before this cycle's write lands.
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (w_wr && w_sel_duty && (w_duty_idx == WORD_W'(i)))
                shadow_d[i] = WIDTH'(f_merge(32'(shadow_q[i]), dat_i, w_mask));
            active_d[i] = (!en_q || w_wrap) ? shadow_q[i] : active_q[i];
            pwm_d[i]    = en_q & ((cnt_q < active_q[i]) ^ inv_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            prescale_q <= 16'(PRESCALE_RESET);
            pscnt_q    <= '0;
            pcount_q   <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            en_q       <= en_d;
            inv_q      <= inv_d;
            prescale_q <= prescale_d;
            pscnt_q    <= pscnt_d;
            pcount_q   <= pcount_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign dat_o       = dat_q;
    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_pwm_bank
// Scoreboard-driven bench for wb_pwm_bank (3 channels, 8-bit counter).
// Rev    : 1.0
// ============================================================================
module tb_wb_pwm_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic        err_o;
    logic [2:0]  pwm_out;
    logic        period_tick;

    always #5 clk = ~clk;

    wb_pwm_bank #(
        .CHANNELS      (3),
        .WIDTH         (8),
        .ADDR_WIDTH    (8),
        .PRESCALE_RESET(1881)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .we_i       (we_i),
        .sel_i      (sel_i),
        .stb_i      (stb_i),
        .cyc_i      (cyc_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        ack;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    exp_cnt_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    cyc_cnt = 0;

    always @(posedge clk) cyc_cnt++;

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd,
                       output logic ack, output logic err, output int lat);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack_o || err_o) && lat < 8);
        rd = dat_o; ack = ack_o; err = err_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (!(ack || err)) begin
            n_total++;
            $display("FAIL bus_timeout adr=%h: got no response, required ack or err within 8 cycles", a);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd; logic ack, err; int lat;
        bus(1'b1, a, d, 4'hF, rd, ack, err, lat);
    endtask

    task automatic wait_tick(input string name);
        int t = 0;
        while (period_tick !== 1'b1 && t < 700) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (period_tick !== 1'b1) $display("FAIL %s: period_tick got 0 after %0d cycles, required 1", name, t);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [7:0] addrs [4] = '{8'h00, 8'h04, 8'h10, 8'h08};
        logic [31:0] rd; logic ack, err; int lat; resp_t e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({ack_o, err_o, period_tick, pwm_out} !== 6'b0 || dat_o !== 32'h0)
            $display("FAIL reset_outputs: got ack=%b err=%b tick=%b pwm=%b dat=%h, required all 0",
                     ack_o, err_o, period_tick, pwm_out, dat_o);
        else n_pass++;
        rst = 1'b0;
        exp_q.push_back('{data: 32'd0,    ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'd1881, ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'd0,    ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'd0,    ack: 1'b1, err: 1'b0});
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, addrs[i], 32'h0, 4'hF, rd, ack, err, lat);
            e = exp_q.pop_front();
            n_total++;
            if (rd !== e.data || ack !== e.ack || err !== e.err || lat != 1)
                $display("FAIL reset_read adr=%h: got data=%h ack=%b err=%b lat=%0d, required data=%h ack=%b err=%b lat=1",
                         addrs[i], rd, ack, err, lat, e.data, e.ack, e.err);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (ack_o !== 1'b0) $display("FAIL reset_ack_width adr=%h: ack got %b second cycle, required 0", addrs[i], ack_o);
            else n_pass++;
        end
    endtask

    task automatic test_pwm();
        int h [3]; int nt, last, e;
        wr(8'h04, 32'd0);
        wr(8'h10, 32'd64);
        wr(8'h14, 32'd0);
        wr(8'h18, 32'd255);
        wr(8'h00, 32'd1);
        exp_cnt_q.push_back(64);
        exp_cnt_q.push_back(0);
        exp_cnt_q.push_back(255);
        exp_cnt_q.push_back(1);
        exp_cnt_q.push_back(255);
        wait_tick("pwm_first_tick");
        h = '{0, 0, 0}; nt = 0; last = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) h[c] += int'(pwm_out[c]);
            if (period_tick) begin nt++; last = i; end
        end
        for (int c = 0; c < 3; c++) begin
            e = exp_cnt_q.pop_front();
            n_total++;
            if (h[c] != e) $display("FAIL pwm_high_count ch%0d: got %0d, required %0d", c, h[c], e);
            else n_pass++;
        end
        e = exp_cnt_q.pop_front();
        n_total++;
        if (nt != e) $display("FAIL pwm_tick_count: got %0d, required %0d", nt, e);
        else n_pass++;
        e = exp_cnt_q.pop_front();
        n_total++;
        if (last != e) $display("FAIL pwm_tick_interval: got %0d, required %0d", last, e);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic ack, err; int lat, t0, ha, hb, e;
        wait_tick("wrap_tick");
        t0 = cyc_cnt;
        wr(8'h10, 32'd10);
        while (cyc_cnt < t0 + 253) @(negedge clk);
        bus(1'b1, 8'h10, 32'd200, 4'hF, rd, ack, err, lat);
        n_total++;
        if (ack !== 1'b1 || lat != 1 || period_tick !== 1'b1)
            $display("FAIL wrap_write: got ack=%b lat=%0d tick=%b, required ack=1 lat=1 tick=1", ack, lat, period_tick);
        else n_pass++;
        exp_cnt_q.push_back(10);
        exp_cnt_q.push_back(200);
        ha = 0; hb = 0;
        for (int i = 1; i <= 510; i++) begin
            @(negedge clk);
            if (i <= 255) ha += int'(pwm_out[0]);
            else          hb += int'(pwm_out[0]);
        end
        e = exp_cnt_q.pop_front();
        n_total++;
        if (ha != e) $display("FAIL wrap_old_shadow: got %0d high clks, required %0d", ha, e);
        else n_pass++;
        e = exp_cnt_q.pop_front();
        n_total++;
        if (hb != e) $display("FAIL wrap_new_shadow: got %0d high clks, required %0d", hb, e);
        else n_pass++;
    endtask

    task automatic test_bytelane();
        logic [31:0] rd; logic ack, err; int lat; resp_t e;
        logic        op_we [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  op_a  [8] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h40, 8'h0C, 8'h08, 8'h10};
        logic [31:0] op_d  [8] = '{32'h1234, 0, 32'hAB00, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0};
        logic [3:0]  op_s  [8] = '{4'b0001, 4'hF, 4'b0010, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        wr(8'h00, 32'd0);
        exp_q.push_back('{data: 32'h0,    ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'h34,   ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'h34,   ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'hAB34, ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'h0,    ack: 1'b0, err: 1'b1});
        exp_q.push_back('{data: 32'h0,    ack: 1'b0, err: 1'b1});
        exp_q.push_back('{data: 32'h0,    ack: 1'b1, err: 1'b0});
        exp_q.push_back('{data: 32'd200,  ack: 1'b1, err: 1'b0});
        for (int i = 0; i < 8; i++) begin
            bus(op_we[i], op_a[i], op_d[i], op_s[i], rd, ack, err, lat);
            e = exp_q.pop_front();
            n_total++;
            if (ack !== e.ack || err !== e.err || lat != 1 || (!op_we[i] && rd !== e.data) || (err && rd !== 32'h0))
                $display("FAIL bytelane op%0d adr=%h: got data=%h ack=%b err=%b lat=%0d, required data=%h ack=%b err=%b lat=1",
                         i, op_a[i], rd, ack, err, lat, e.data, e.ack, e.err);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (err_o !== 1'b0 || ack_o !== 1'b0) $display("FAIL bytelane_idle: got ack=%b err=%b, required 0 0", ack_o, err_o);
        else n_pass++;
        bus(1'b0, 8'h04, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (rd !== 32'hAB34) $display("FAIL bytelane_prescale_kept: got %h, required %h", rd, 32'hAB34);
        else n_pass++;
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (rd[7:0] !== 8'h0) $display("FAIL status_counter_idle: got %h, required 00", rd[7:0]);
        else n_pass++;
    endtask

    task automatic test_inv();
        logic [31:0] rd; logic ack, err; int lat, bad, nt;
        wr(8'h04, 32'd0);
        wr(8'h10, 32'd0);
        wr(8'h00, 32'd3);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm_out !== 3'b011) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL inv_outputs: got %0d cycles off 011, required 0", bad);
        else n_pass++;
        wr(8'h00, 32'd2);
        @(negedge clk);
        n_total++;
        if (pwm_out !== 3'b000) $display("FAIL inv_disable: pwm got %b, required 000", pwm_out);
        else n_pass++;
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (period_tick !== 1'b0 || pwm_out !== 3'b000) nt++;
        end
        n_total++;
        if (nt != 0) $display("FAIL disabled_quiet: got %0d active cycles, required 0", nt);
        else n_pass++;
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (ack !== 1'b1 || rd[7:0] !== 8'h0) $display("FAIL inv_status: got ack=%b cnt=%h, required ack=1 cnt=00", ack, rd[7:0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ack, err; int lat, nack, bad;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h00; sel_i = 4'hF;
        nack = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_o) begin
                nack++;
                if (dat_o !== 32'd2) bad++;
            end
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        n_total++;
        if (nack != 4 || bad != 0) $display("FAIL held_stb: got %0d acks (%0d bad data), required 4 (0)", nack, bad);
        else n_pass++;
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h00; dat_i = 32'd1;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_o || err_o) nack++;
        end
        stb_i = 1'b0; we_i = 1'b0;
        n_total++;
        if (nack != 0) $display("FAIL stb_without_cyc: got %0d responses, required 0", nack);
        else n_pass++;
        bus(1'b0, 8'h00, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (rd !== 32'd2) $display("FAIL stb_without_cyc_ctrl: got %h, required %h", rd, 32'd2);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd; logic ack, err; int lat;
        wr(8'h00, 32'd1);
        repeat (5) @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h00; dat_i = 32'd3; sel_i = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || pwm_out !== 3'b000)
            $display("FAIL rst_mid: got ack=%b err=%b pwm=%b, required 0 0 000", ack_o, err_o, pwm_out);
        else n_pass++;
        rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        bus(1'b0, 8'h00, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (rd !== 32'd0 || ack !== 1'b1) $display("FAIL rst_mid_ctrl: got %h ack=%b, required 0 ack=1", rd, ack);
        else n_pass++;
        bus(1'b1, 8'h00, 32'd1, 4'hF, rd, ack, err, lat);
        n_total++;
        if (ack !== 1'b1 || lat != 1) $display("FAIL rst_retry_write: got ack=%b lat=%0d, required ack=1 lat=1", ack, lat);
        else n_pass++;
        bus(1'b0, 8'h00, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (rd !== 32'd1) $display("FAIL rst_retry_ctrl: got %h, required %h", rd, 32'd1);
        else n_pass++;
        bus(1'b0, 8'h04, 32'h0, 4'hF, rd, ack, err, lat);
        n_total++;
        if (rd !== 32'd1881) $display("FAIL rst_prescale: got %0d, required 1881", rd);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = '0; stb_i = 1'b0; cyc_i = 1'b0;
        test_reset();
        test_pwm();
        test_wrap();
        test_bytelane();
        test_inv();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
